// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift sequencing controller.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit counter must hold 0..sr_w inclusive.
  function automatic int bit_cnt_width(input int sr_w);
    return $clog2(sr_w + 1);
  endfunction

endpackage

// File: rtl/shift_reg_core.sv
// Serial-in/parallel-out shift register; direction chosen at elaboration.
module shift_reg_core #(
  parameter int SR_W      = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            x_i,
  output logic [SR_W-1:0] sr_o
);

  logic [SR_W-1:0] sr_reg;
  logic [SR_W-1:0] sr_next;

  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign sr_next = {x_i, sr_reg[SR_W-1:1]};
    end else begin : g_msb_first
      assign sr_next = {sr_reg[SR_W-2:0], x_i};
    end
  endgenerate

  // Clear wins over shift so an abort in the same cycle leaves the register empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_reg <= '0;
    end else if (clr_i) begin
      sr_reg <= '0;
    end else if (en_i) begin
      sr_reg <= sr_next;
    end
  end

  assign sr_o = sr_reg;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequences a parallel word into a serial shift register and hands the full word on.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int SR_W      = 4,
  parameter int LSB_FIRST = 0,
  parameter int CNT_W     = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [SR_W-1:0]                 in_data_i,
  input  logic                            abort_i,
  output logic                            x_o,
  output logic                            shift_en_o,
  output logic [SR_W-1:0]                 sr_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            busy_o,
  output logic [bit_cnt_width(SR_W)-1:0]  bit_cnt_o,
  output logic [CNT_W-1:0]                done_cnt_o
);

  localparam int BCW = bit_cnt_width(SR_W);

  state_t           state_reg, state_next;
  logic [SR_W-1:0]  hold_reg;
  logic [BCW-1:0]   bit_cnt_reg;
  logic [CNT_W-1:0] done_cnt_reg;

  logic             accept;
  logic             abort_act;
  logic             last_bit;
  logic             handshake;
  logic [BCW-1:0]   bit_idx;
  logic [SR_W-1:0]  hold_shifted;

  assign accept    = in_valid_i && in_ready_o;
  assign abort_act = abort_i && (state_reg != IDLE);
  assign last_bit  = (bit_cnt_reg == BCW'(SR_W - 1));
  // Abort outranks the output handshake when both land in DONE.
  assign handshake = (state_reg == DONE) && out_ready_i && !abort_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort_act) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE:    if (accept) state_next = CLEAR;
        CLEAR:   state_next = SHIFT;
        SHIFT:   if (last_bit) state_next = DONE;
        DONE:    if (out_ready_i) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_o   = (state_reg == IDLE) && !abort_i;
    busy_o       = (state_reg != IDLE);
    shift_en_o   = (state_reg == SHIFT);
    out_valid_o  = (state_reg == DONE);
    bit_idx      = (LSB_FIRST != 0) ? bit_cnt_reg : (BCW'(SR_W - 1) - bit_cnt_reg);
    hold_shifted = hold_reg >> bit_idx;
    x_o          = (state_reg == SHIFT) ? hold_shifted[0] : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg     <= '0;
      bit_cnt_reg  <= '0;
      done_cnt_reg <= '0;
    end else begin
      if (accept) begin
        hold_reg <= in_data_i;
      end
      // Counter parks at SR_W in DONE and returns to 0 on leaving it.
      if (abort_act || (state_reg == CLEAR) || handshake) begin
        bit_cnt_reg <= '0;
      end else if (state_reg == SHIFT) begin
        bit_cnt_reg <= bit_cnt_reg + BCW'(1);
      end
      if (handshake) begin
        done_cnt_reg <= done_cnt_reg + CNT_W'(1);
      end
    end
  end

  shift_reg_core #(
    .SR_W      (SR_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (abort_act || (state_reg == CLEAR)),
    .en_i    (shift_en_o),
    .x_i     (x_o),
    .sr_o    (sr_o)
  );

  assign bit_cnt_o  = bit_cnt_reg;
  assign done_cnt_o = done_cnt_reg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Drives an MSB-first (CNT_W=8) and an LSB-first (CNT_W=2) controller with shared stimulus.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       abort;
  logic       out_ready;

  logic       in_ready  [2];
  logic       x         [2];
  logic       shift_en  [2];
  logic [3:0] sr        [2];
  logic       out_valid [2];
  logic       busy      [2];
  logic [2:0] bit_cnt   [2];
  logic [7:0] done0;
  logic [1:0] done1;

  int total = 0;
  int bad   = 0;
  int exp_done = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.SR_W(4), .LSB_FIRST(0), .CNT_W(8)) dut_msb (
    .clk(clk), .reset_n(reset_n), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
    .in_data_i(in_data), .abort_i(abort), .x_o(x[0]), .shift_en_o(shift_en[0]),
    .sr_o(sr[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
    .busy_o(busy[0]), .bit_cnt_o(bit_cnt[0]), .done_cnt_o(done0)
  );

  shift_seq_ctrl #(.SR_W(4), .LSB_FIRST(1), .CNT_W(2)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
    .in_data_i(in_data), .abort_i(abort), .x_o(x[1]), .shift_en_o(shift_en[1]),
    .sr_o(sr[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
    .busy_o(busy[1]), .bit_cnt_o(bit_cnt[1]), .done_cnt_o(done1)
  );

  // Register contents after k bits have entered.
  function automatic logic [3:0] sr_model(input int m, input logic [3:0] w, input int k);
    logic [7:0] t;
    if (m == 0) return w >> (4 - k);
    t = {4'b0, w} << (4 - k);
    return t[3:0];
  endfunction

  // Bit on the serial line during the k-th shift cycle.
  function automatic logic x_model(input int m, input logic [3:0] w, input int k);
    logic [3:0] t;
    t = w;
    return (m == 0) ? t[3 - k] : t[k];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk_done;
    chk("done_cnt_msb", 32'(done0), 32'(exp_done % 256));
    chk("done_cnt_lsb", 32'(done1), 32'(exp_done % 4));
  endtask

  task automatic send(input logic [3:0] w, input int delay, input bit chain, input logic [3:0] nw);
    in_valid = 1'b1; in_data = w; abort = 1'b0; out_ready = 1'b0;
    settle;
    for (int m = 0; m < 2; m++) chk("in_ready_idle", 32'(in_ready[m]), 32'd1);
    tick;
    in_valid = 1'b0; in_data = 4'($urandom);
    settle;
    for (int m = 0; m < 2; m++) begin
      chk("clear_busy", 32'(busy[m]), 32'd1);
      chk("clear_shift_en", 32'(shift_en[m]), 32'd0);
      chk("clear_x", 32'(x[m]), 32'd0);
      chk("clear_bit_cnt", 32'(bit_cnt[m]), 32'd0);
    end
    tick;
    for (int k = 0; k < 4; k++) begin
      for (int m = 0; m < 2; m++) begin
        chk("shift_en", 32'(shift_en[m]), 32'd1);
        chk("x_bit", 32'(x[m]), 32'(x_model(m, w, k)));
        chk("bit_cnt", 32'(bit_cnt[m]), 32'(k));
      end
      tick;
      for (int m = 0; m < 2; m++) begin
        chk("sr_partial", 32'(sr[m]), 32'(sr_model(m, w, k + 1)));
        chk("out_valid_timing", 32'(out_valid[m]), 32'(k == 3));
      end
    end
    if (chain) begin
      in_valid = 1'b1; in_data = nw;
    end
    settle;
    for (int m = 0; m < 2; m++) begin
      chk("done_in_ready", 32'(in_ready[m]), 32'd0);
      chk("done_bit_cnt", 32'(bit_cnt[m]), 32'd4);
      chk("done_x", 32'(x[m]), 32'd0);
    end
    repeat (delay) begin
      tick;
      for (int m = 0; m < 2; m++) begin
        chk("bp_out_valid", 32'(out_valid[m]), 32'd1);
        chk("bp_sr_stable", 32'(sr[m]), 32'(w));
        chk("bp_in_ready", 32'(in_ready[m]), 32'd0);
      end
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    exp_done++;
    settle;
    chk_done();
    for (int m = 0; m < 2; m++) begin
      chk("post_busy", 32'(busy[m]), 32'd0);
      chk("post_in_ready", 32'(in_ready[m]), 32'd1);
      chk("post_out_valid", 32'(out_valid[m]), 32'd0);
      chk("post_bit_cnt", 32'(bit_cnt[m]), 32'd0);
    end
    $display("word %h delivered, delay=%0d, done=%0d", w, delay, exp_done);
  endtask

  task automatic abort_at(input logic [3:0] w, input int k, input bit in_done);
    in_valid = 1'b1; in_data = w; abort = 1'b0; out_ready = 1'b0;
    settle;
    tick;
    in_valid = 1'b0;
    tick;
    repeat (k) tick;
    abort = 1'b1; out_ready = in_done;
    settle;
    for (int m = 0; m < 2; m++) chk("abort_bit_cnt", 32'(bit_cnt[m]), 32'(k));
    tick;
    abort = 1'b0; out_ready = 1'b0;
    settle;
    chk_done();
    for (int m = 0; m < 2; m++) begin
      chk("abort_busy", 32'(busy[m]), 32'd0);
      chk("abort_sr", 32'(sr[m]), 32'd0);
      chk("abort_bit_cnt_clr", 32'(bit_cnt[m]), 32'd0);
      chk("abort_out_valid", 32'(out_valid[m]), 32'd0);
    end
    repeat (3) begin
      tick;
      for (int m = 0; m < 2; m++) chk("abort_no_valid", 32'(out_valid[m]), 32'd0);
    end
    $display("word %h aborted at bit %0d", w, k);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0; out_ready = 1'b0;
    #12;
    for (int m = 0; m < 2; m++) begin
      chk("rst_sr", 32'(sr[m]), 32'd0);
      chk("rst_busy", 32'(busy[m]), 32'd0);
      chk("rst_shift_en", 32'(shift_en[m]), 32'd0);
      chk("rst_x", 32'(x[m]), 32'd0);
      chk("rst_out_valid", 32'(out_valid[m]), 32'd0);
      chk("rst_bit_cnt", 32'(bit_cnt[m]), 32'd0);
    end
    chk_done();
    reset_n = 1'b1;
    settle;
    for (int m = 0; m < 2; m++) chk("rst_in_ready", 32'(in_ready[m]), 32'd1);
    tick;

    // Directed words, back-pressure with the next word already offered.
    send(4'b1010, 0, 1'b0, 4'b0000);
    send(4'b0011, 0, 1'b0, 4'b0000);
    send(4'b1010, 3, 1'b1, 4'b0110);
    send(4'b0110, 0, 1'b0, 4'b0000);

    abort_at(4'b1101, 2, 1'b0);
    abort_at(4'b1001, 4, 1'b1);

    // Abort in IDLE only blocks acceptance.
    abort = 1'b1; in_valid = 1'b1; in_data = 4'b0101;
    settle;
    for (int m = 0; m < 2; m++) chk("idle_abort_ready", 32'(in_ready[m]), 32'd0);
    tick;
    abort = 1'b0; in_valid = 1'b0;
    settle;
    for (int m = 0; m < 2; m++) chk("idle_abort_busy", 32'(busy[m]), 32'd0);
    tick;

    // Reset dropped between edges while shifting.
    in_valid = 1'b1; in_data = 4'b1111;
    settle;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    #2 reset_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("mid_rst_sr", 32'(sr[m]), 32'd0);
      chk("mid_rst_busy", 32'(busy[m]), 32'd0);
      chk("mid_rst_shift_en", 32'(shift_en[m]), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid[m]), 32'd0);
    end
    #1 reset_n = 1'b1;
    exp_done = 0;
    #1;
    chk_done();
    for (int m = 0; m < 2; m++) chk("mid_rst_in_ready", 32'(in_ready[m]), 32'd1);
    $display("reset applied mid-shift");
    tick;

    // Four back-to-back words: the 2-bit counter wraps to 0.
    for (int i = 0; i < 4; i++) send(4'($urandom), 0, 1'b0, 4'b0000);
    chk("wrap_lsb", 32'(done1), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0)
        abort_at(4'($urandom), $urandom_range(0, 4), 1'($urandom));
      else
        send(4'($urandom), $urandom_range(0, 2), 1'b0, 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
